// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute / write-back stage that sits directly behind the 16x8 register file.
// A decoded op is accepted in IDLE, the source addresses go straight to the
// register file read ports, the registered read data is consumed one cycle
// later (OPWAIT), the result is computed (single-cycle ALU or the optional
// shift-add multiplier) and returned through the register file write port.
// The stage also owns the architectural flags {Z,N,C,V}.
//
// Optional feature: define ALU_EXEC_MUL_EN to build the multiplier
// (opcode 9). Without it, opcode 9 is treated as an illegal opcode and the
// MUL state/datapath is not built.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   issue_valid/ready      op handshake; ready is high only in IDLE
//   issue_op/dst/src1/src2 decoded op fields
//   rf_read_address1/2     combinational copies of issue_src1/2
//   rf_read_data1/2        register file read data (one cycle after address)
//   rf_write_address/data  write-back address/data (hold when not writing)
//   rf_write_enable        one-cycle write-back strobe
//   flags                  {Z,N,C,V}
//   illegal_op             one-cycle pulse for an undefined opcode
//   busy                   high whenever the FSM is not in IDLE
//
// Timing: an op accepted at edge T writes back in the cycle after edge T+2
// (T+2+DATA_W for MUL). The write strobe is registered out of WB, so it is
// high while the FSM is already back in IDLE; the next op may therefore read
// on the same edge the write lands, and the register file resolves that
// write-first.
// -----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_op,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic [ADDR_W-1:0] issue_src1,
    input  logic [ADDR_W-1:0] issue_src2,
    output logic [ADDR_W-1:0] rf_read_address1,
    output logic [ADDR_W-1:0] rf_read_address2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [3:0]        flags,
    output logic              illegal_op,
    output logic              busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPWAIT = 2'd1,
        S_MUL    = 2'd2,
        S_WB     = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              c;
        logic              v;
        logic              wb;     // result goes to the register file
        logic              legal;  // opcode is a single-cycle ALU op
    } alu_res_t;

    // Single-cycle ALU. Carry/borrow come from an unsigned DATA_W+1 result,
    // overflow from a sign-extended signed result disagreeing in its top two bits.
    function automatic alu_res_t alu_eval(input logic [3:0]        op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        alu_res_t               r;
        logic [DATA_W:0]        ext;
        logic signed [DATA_W:0] sext;
        r       = '0;
        r.legal = 1'b1;
        r.wb    = 1'b1;
        ext     = '0;
        sext    = '0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                sext  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
                r.res = ext[DATA_W-1:0];
                r.c   = ext[DATA_W];
                r.v   = sext[DATA_W] ^ sext[DATA_W-1];
            end
            OP_SUB, OP_CMP: begin
                ext   = {1'b0, a} - {1'b0, b};
                sext  = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
                r.res = ext[DATA_W-1:0];
                r.c   = ext[DATA_W];          // borrow: a < b unsigned
                r.v   = sext[DATA_W] ^ sext[DATA_W-1];
                r.wb  = (op != OP_CMP);
            end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_XOR: r.res = a ^ b;
            OP_SHL: begin
                r.res = {a[DATA_W-2:0], 1'b0};
                r.c   = a[DATA_W-1];
            end
            OP_SHR: begin
                r.res = {1'b0, a[DATA_W-1:1]};
                r.c   = a[0];
            end
            OP_MOV: r.res = b;
            default: begin
                r.legal = 1'b0;
                r.wb    = 1'b0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] res,
                                              input logic              c,
                                              input logic              v);
        return {(res == '0), res[DATA_W-1], c, v};
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] res_q;
    logic              wb_pend_q;
    logic [3:0]        flags_q;
    logic              we_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic              illegal_q;
    alu_res_t          alu_r;

    assign alu_r = alu_eval(op_q, rf_read_data1, rf_read_data2);

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0]       OP_MUL   = 4'd9;
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] prod_next;
    logic                mul_last;

    // Accumulator after adding this cycle's partial product; on the last
    // iteration this is the full product.
    assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (cnt_q == CNT_LAST);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_valid) state_d = S_OPWAIT;
            end
            S_OPWAIT: begin
`ifdef ALU_EXEC_MUL_EN
                if (op_q == OP_MUL)   state_d = S_MUL;
                else
`endif
                if (alu_r.legal)      state_d = S_WB;
                else                  state_d = S_IDLE;
            end
            S_MUL: begin
`ifdef ALU_EXEC_MUL_EN
                if (mul_last) state_d = S_WB;
`else
                state_d = S_IDLE;
`endif
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        issue_ready      = (state_q == S_IDLE);
        busy             = (state_q != S_IDLE);
        rf_read_address1 = issue_src1;
        rf_read_address2 = issue_src2;
        rf_write_enable  = we_q;
        rf_write_address = wa_q;
        rf_write_data    = wd_q;
        flags            = flags_q;
        illegal_op       = illegal_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            dst_q     <= '0;
            res_q     <= '0;
            wb_pend_q <= 1'b0;
            flags_q   <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            we_q      <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (issue_valid) begin
                        op_q  <= issue_op;
                        dst_q <= issue_dst;
                    end
                end
                S_OPWAIT: begin
`ifdef ALU_EXEC_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc_q    <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, rf_read_data1};
                        mplier_q <= rf_read_data2;
                        cnt_q    <= '0;
                    end else
`endif
                    if (alu_r.legal) begin
                        res_q     <= alu_r.res;
                        wb_pend_q <= alu_r.wb;
                        flags_q   <= pack_flags(alu_r.res, alu_r.c, alu_r.v);
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                S_MUL: begin
                    acc_q    <= prod_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (mul_last) begin
                        res_q     <= prod_next[DATA_W-1:0];
                        wb_pend_q <= 1'b1;
                        flags_q   <= pack_flags(prod_next[DATA_W-1:0],
                                                |prod_next[2*DATA_W-1:DATA_W], 1'b0);
                    end
                end
`endif
                S_WB: begin
                    // CMP passes through WB with nothing pending.
                    if (wb_pend_q) begin
                        we_q <= 1'b1;
                        wa_q <= dst_q;
                        wd_q <= res_q;
                    end
                    wb_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
